// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree over 2**N_STAGE weighted synapse lanes, with a saturating
// accumulator that integrates time-multiplexed beats into one total per frame.
module pipelined_adder_tree #(
    parameter int N_STAGE = 5,
    parameter int W_IN    = 2,
    parameter int SIGNED  = 0,
    parameter int ACC_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [W_IN*(2**N_STAGE)-1:0] wx,
    input  logic                         clear,
    output logic                         tree_valid,
    output logic [W_IN+N_STAGE-1:0]      tree_sum,
    output logic                         acc_valid,
    output logic [ACC_W-1:0]             acc_out,
    output logic                         acc_sat
);
    localparam int N_IN      = 2**N_STAGE;
    localparam int W_T       = W_IN + N_STAGE;
    localparam bit IS_SIGNED = (SIGNED != 0);

    if (ACC_W < W_T) begin : g_badAccW
        $error("pipelined_adder_tree: ACC_W must be at least W_IN+N_STAGE");
    end

    logic [N_STAGE:1] r_valid;
    logic [N_STAGE:1] r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[1] <= in_valid;
            r_last[1]  <= in_valid & in_last;
            for (int s = 2; s <= N_STAGE; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_last[s]  <= r_last[s-1];
            end
        end
    end

    // Each node widens by one bit so the pairwise sum is exact; data needs no reset
    // because every consumer is qualified by the matching valid bit.
    for (genvar s = 1; s <= N_STAGE; s++) begin : g_stage
        localparam int NL = N_IN >> s;
        localparam int WI = W_IN + s - 1;
        for (genvar k = 0; k < NL; k++) begin : g_node
            logic [WI-1:0] w_a;
            logic [WI-1:0] w_b;
            logic [WI:0]   r_sum;
            if (s == 1) begin : g_leaf
                assign w_a = wx[W_IN*(2*k)   +: W_IN];
                assign w_b = wx[W_IN*(2*k+1) +: W_IN];
            end else begin : g_inner
                assign w_a = g_stage[s-1].g_node[2*k].r_sum;
                assign w_b = g_stage[s-1].g_node[2*k+1].r_sum;
            end
            always_ff @(posedge clk) begin
                r_sum <= {IS_SIGNED & w_a[WI-1], w_a} + {IS_SIGNED & w_b[WI-1], w_b};
            end
        end
    end

    logic [W_T-1:0] w_treeSum;
    assign w_treeSum  = g_stage[N_STAGE].g_node[0].r_sum;
    assign tree_valid = r_valid[N_STAGE];
    assign tree_sum   = r_valid[N_STAGE] ? w_treeSum : '0;

    logic [ACC_W-1:0] r_acc;
    logic             r_frameSat;
    logic             w_treeSign;
    logic [ACC_W:0]   w_sumExt;
    logic [ACC_W-1:0] w_satSum;
    logic             w_clip;

    // One guard bit is enough: the tree sum always fits in ACC_W bits.
    assign w_treeSign = IS_SIGNED & w_treeSum[W_T-1];
    assign w_sumExt   = {IS_SIGNED & r_acc[ACC_W-1], r_acc}
                      + {{(ACC_W+1-W_T){w_treeSign}}, w_treeSum};

    always_comb begin
        w_clip   = 1'b0;
        w_satSum = w_sumExt[ACC_W-1:0];
        if (IS_SIGNED) begin
            if (w_sumExt[ACC_W] != w_sumExt[ACC_W-1]) begin
                w_clip   = 1'b1;
                w_satSum = w_sumExt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (w_sumExt[ACC_W]) begin
            w_clip   = 1'b1;
            w_satSum = '1;
        end
    end

    // A flush wins over the beat arriving in the same cycle, last flag included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_frameSat <= 1'b0;
            acc_valid  <= 1'b0;
            acc_out    <= '0;
            acc_sat    <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (clear) begin
                r_acc      <= '0;
                r_frameSat <= 1'b0;
            end else if (r_valid[N_STAGE]) begin
                if (r_last[N_STAGE]) begin
                    acc_out    <= w_satSum;
                    acc_sat    <= r_frameSat | w_clip;
                    acc_valid  <= 1'b1;
                    r_acc      <= '0;
                    r_frameSat <= 1'b0;
                end else begin
                    r_acc      <= w_satSum;
                    r_frameSat <= r_frameSat | w_clip;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: four configurations share one stimulus stream and
// are checked every cycle against a frame-level arithmetic model, plus vector tables.
module tb_pipelined_adder_tree;
    localparam int N_STAGE = 5;
    localparam int W_IN    = 2;
    localparam int N_IN    = 32;
    localparam int W_T     = 7;
    localparam int N_CFG   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        clear;
    logic [63:0] wx;

    logic        tvU, tvS, tvU8, tvS8;
    logic [6:0]  tsU, tsS, tsU8, tsS8;
    logic        avU, avS, avU8, avS8;
    logic [15:0] aoU, aoS;
    logic [7:0]  aoU8, aoS8;
    logic        asU, asS, asU8, asS8;

    always #5 clk = ~clk;

    pipelined_adder_tree #(.N_STAGE(5), .W_IN(2), .SIGNED(0), .ACC_W(16)) u_dutU (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .wx(wx),
        .clear(clear), .tree_valid(tvU), .tree_sum(tsU), .acc_valid(avU),
        .acc_out(aoU), .acc_sat(asU));
    pipelined_adder_tree #(.N_STAGE(5), .W_IN(2), .SIGNED(1), .ACC_W(16)) u_dutS (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .wx(wx),
        .clear(clear), .tree_valid(tvS), .tree_sum(tsS), .acc_valid(avS),
        .acc_out(aoS), .acc_sat(asS));
    pipelined_adder_tree #(.N_STAGE(5), .W_IN(2), .SIGNED(0), .ACC_W(8)) u_dutU8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .wx(wx),
        .clear(clear), .tree_valid(tvU8), .tree_sum(tsU8), .acc_valid(avU8),
        .acc_out(aoU8), .acc_sat(asU8));
    pipelined_adder_tree #(.N_STAGE(5), .W_IN(2), .SIGNED(1), .ACC_W(8)) u_dutS8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .wx(wx),
        .clear(clear), .tree_valid(tvS8), .tree_sum(tsS8), .acc_valid(avS8),
        .acc_out(aoS8), .acc_sat(asS8));

    logic        actTv [N_CFG];
    logic        actAv [N_CFG];
    logic        actAs [N_CFG];
    logic [63:0] actTs [N_CFG];
    logic [63:0] actAo [N_CFG];

    always_comb begin
        actTv[0] = tvU;  actTv[1] = tvS;  actTv[2] = tvU8;  actTv[3] = tvS8;
        actAv[0] = avU;  actAv[1] = avS;  actAv[2] = avU8;  actAv[3] = avS8;
        actAs[0] = asU;  actAs[1] = asS;  actAs[2] = asU8;  actAs[3] = asS8;
        actTs[0] = {57'd0, tsU};  actTs[1] = {57'd0, tsS};
        actTs[2] = {57'd0, tsU8}; actTs[3] = {57'd0, tsS8};
        actAo[0] = {48'd0, aoU};  actAo[1] = {48'd0, aoS};
        actAo[2] = {56'd0, aoU8}; actAo[3] = {56'd0, aoS8};
    end

    typedef struct {
        bit     v;
        bit     last;
        longint su;
        longint ss;
    } beat_t;

    typedef struct {
        int laneVal;
        int nBeats;
        int expTree;
        int expAccU;  bit expSatU;
        int expAccS;  bit expSatS;
        int expAccU8; bit expSatU8;
        int expAccS8; bit expSatS8;
    } vec_t;

    beat_t       pipe [$];
    longint      mAcc [N_CFG];
    longint      mAccOut [N_CFG];
    bit          mFsat [N_CFG];
    bit          mAccSat [N_CFG];
    bit          mAccValid [N_CFG];

    int          nChecks = 0;
    int          nPass = 0;
    int          tvCnt;
    int          avCnt;
    logic [63:0] capAcc [N_CFG];
    logic        capSat [N_CFG];
    logic [63:0] capTree;

    function automatic bit cfgSigned(input int c);
        return (c == 1) || (c == 3);
    endfunction

    function automatic int cfgAccW(input int c);
        return (c < 2) ? 16 : 8;
    endfunction

    function automatic logic [63:0] maskW(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic beat_t idleBeat();
        beat_t b;
        b.v = 1'b0; b.last = 1'b0; b.su = 0; b.ss = 0;
        return b;
    endfunction

    function automatic logic [63:0] allLanes(input int val);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < N_IN; j++) r[W_IN*j +: W_IN] = 2'(val);
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Model: a beat's sum is the plain sum of its lane values, seen N_STAGE cycles
    // later; the accumulator integrates with clipping to the configured range.
    task automatic modelUpdate();
        beat_t  head, nb;
        longint t, s, hi, lo;
        bit     clip;
        int     v;
        if (!rst_n) begin
            pipe.delete();
            for (int i = 0; i < N_STAGE; i++) pipe.push_back(idleBeat());
            for (int c = 0; c < N_CFG; c++) begin
                mAcc[c] = 0; mAccOut[c] = 0; mFsat[c] = 1'b0;
                mAccSat[c] = 1'b0; mAccValid[c] = 1'b0;
            end
            return;
        end
        head = pipe[0];
        for (int c = 0; c < N_CFG; c++) begin
            mAccValid[c] = 1'b0;
            if (cfgSigned(c)) begin
                hi = (longint'(1) << (cfgAccW(c) - 1)) - 1;
                lo = -hi - 1;
            end else begin
                hi = (longint'(1) << cfgAccW(c)) - 1;
                lo = 0;
            end
            if (clear) begin
                mAcc[c] = 0;
                mFsat[c] = 1'b0;
            end else if (head.v) begin
                t = cfgSigned(c) ? head.ss : head.su;
                s = mAcc[c] + t;
                clip = 1'b0;
                if (s > hi) begin s = hi; clip = 1'b1; end
                if (s < lo) begin s = lo; clip = 1'b1; end
                if (head.last) begin
                    mAccOut[c] = s;
                    mAccSat[c] = mFsat[c] | clip;
                    mAccValid[c] = 1'b1;
                    mAcc[c] = 0;
                    mFsat[c] = 1'b0;
                end else begin
                    mAcc[c] = s;
                    mFsat[c] = mFsat[c] | clip;
                end
            end
        end
        nb = idleBeat();
        if (in_valid) begin
            nb.v = 1'b1;
            nb.last = in_last;
            for (int j = 0; j < N_IN; j++) begin
                v = int'((wx >> (W_IN*j)) & 64'd3);
                nb.su += v;
                nb.ss += (v >= 2) ? v - 4 : v;
            end
        end
        void'(pipe.pop_front());
        pipe.push_back(nb);
    endtask

    task automatic checkOutput();
        for (int c = 0; c < N_CFG; c++) begin
            string p;
            p = $sformatf("cfg%0d ", c);
            checkVal({p, "tree_valid"}, 64'(actTv[c]), 64'(pipe[0].v));
            if (pipe[0].v)
                checkVal({p, "tree_sum"}, actTs[c],
                         maskW(cfgSigned(c) ? pipe[0].ss : pipe[0].su, W_T));
            checkVal({p, "acc_valid"}, 64'(actAv[c]), 64'(mAccValid[c]));
            checkVal({p, "acc_out"}, actAo[c], maskW(mAccOut[c], cfgAccW(c)));
            checkVal({p, "acc_sat"}, 64'(actAs[c]), 64'(mAccSat[c]));
        end
    endtask

    task automatic applyStimulus(input bit v, input bit last, input bit clr, input logic [63:0] lanes);
        in_valid = v;
        in_last  = last;
        clear    = clr;
        wx       = lanes;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput();
        tvCnt += int'(actTv[0]);
        avCnt += int'(actAv[0]);
        if (actTv[0]) capTree = actTs[0];
        for (int c = 0; c < N_CFG; c++) begin
            if (actAv[c]) begin
                capAcc[c] = actAo[c];
                capSat[c] = actAs[c];
            end
        end
    endtask

    task automatic clearCaptures();
        tvCnt = 0;
        avCnt = 0;
        capTree = 64'hDEAD;
        for (int c = 0; c < N_CFG; c++) begin
            capAcc[c] = 64'hDEAD;
            capSat[c] = 1'bx;
        end
    endtask

    task automatic measureLatency(input int laneVal, input int expSum);
        int firstTv, firstAv;
        firstTv = -1;
        firstAv = -1;
        clearCaptures();
        applyStimulus(1'b1, 1'b1, 1'b0, allLanes(laneVal));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        for (int i = 1; i <= N_STAGE + 3; i++) begin
            tick();
            if (actTv[0] && firstTv < 0) firstTv = i;
            if (actAv[0] && firstAv < 0) firstAv = i;
        end
        checkVal("latency tree_valid", 64'(firstTv), 64'(N_STAGE - 1));
        checkVal("latency acc_valid", 64'(firstAv), 64'(N_STAGE));
        checkVal("latency tree_sum", capTree, 64'(expSum));
        checkVal("latency acc_out", capAcc[0], 64'(expSum));
        checkVal("latency acc_sat", 64'(capSat[0]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{3, 1, 96, 96,  1'b0, 'hFFE0, 1'b0, 96,  1'b0, 'hE0, 1'b0};
        vecs[1] = '{3, 3, 96, 288, 1'b0, 'hFFA0, 1'b0, 255, 1'b1, 'hA0, 1'b0};
        vecs[2] = '{1, 1, 32, 32,  1'b0, 32,     1'b0, 32,  1'b0, 'h20, 1'b0};
        vecs[3] = '{2, 1, 64, 64,  1'b0, 'hFFC0, 1'b0, 64,  1'b0, 'hC0, 1'b0};
        vecs[4] = '{0, 2, 0,  0,   1'b0, 0,      1'b0, 0,   1'b0, 0,    1'b0};
        vecs[5] = '{1, 8, 32, 256, 1'b0, 256,    1'b0, 255, 1'b1, 'h7F, 1'b1};
        vecs[6] = '{2, 2, 64, 128, 1'b0, 'hFF80, 1'b0, 128, 1'b0, 'h80, 1'b0};
        vecs[7] = '{3, 5, 96, 480, 1'b0, 'hFF60, 1'b0, 255, 1'b1, 'h80, 1'b1};

        for (int i = 0; i < N_STAGE; i++) pipe.push_back(idleBeat());
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        clearCaptures();
        repeat (3) tick();
        checkVal("reset tree_valid", 64'(actTv[0]), 64'd0);
        checkVal("reset tree_sum", actTs[1], 64'd0);
        checkVal("reset acc_valid", 64'(actAv[0]), 64'd0);
        checkVal("reset acc_out", actAo[0], 64'd0);
        checkVal("reset acc_sat", 64'(actAs[2]), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] latency of a single-beat frame");
        measureLatency(3, 96);

        $display("[TB] vector table of frames");
        for (int r = 0; r < 8; r++) begin
            clearCaptures();
            for (int b = 0; b < vecs[r].nBeats; b++) begin
                applyStimulus(1'b1, b == vecs[r].nBeats - 1, 1'b0, allLanes(vecs[r].laneVal));
                tick();
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
            repeat (N_STAGE + 3) tick();
            checkVal($sformatf("vec%0d tree beats", r), 64'(tvCnt), 64'(vecs[r].nBeats));
            checkVal($sformatf("vec%0d acc pulses", r), 64'(avCnt), 64'd1);
            checkVal($sformatf("vec%0d tree_sum", r), capTree, 64'(vecs[r].expTree));
            checkVal($sformatf("vec%0d accU", r), capAcc[0], 64'(vecs[r].expAccU));
            checkVal($sformatf("vec%0d satU", r), 64'(capSat[0]), 64'(vecs[r].expSatU));
            checkVal($sformatf("vec%0d accS", r), capAcc[1], 64'(vecs[r].expAccS));
            checkVal($sformatf("vec%0d satS", r), 64'(capSat[1]), 64'(vecs[r].expSatS));
            checkVal($sformatf("vec%0d accU8", r), capAcc[2], 64'(vecs[r].expAccU8));
            checkVal($sformatf("vec%0d satU8", r), 64'(capSat[2]), 64'(vecs[r].expSatU8));
            checkVal($sformatf("vec%0d accS8", r), capAcc[3], 64'(vecs[r].expAccS8));
            checkVal($sformatf("vec%0d satS8", r), 64'(capSat[3]), 64'(vecs[r].expSatS8));
        end

        $display("[TB] clear drops the first beat of a two-beat frame");
        clearCaptures();
        applyStimulus(1'b1, 1'b0, 1'b0, allLanes(3));
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, allLanes(3));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        repeat (N_STAGE - 2) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        repeat (N_STAGE + 2) tick();
        checkVal("clear acc pulses", 64'(avCnt), 64'd1);
        checkVal("clear accU", capAcc[0], 64'd96);
        checkVal("clear accS", capAcc[1], 64'hFFE0);
        checkVal("clear accU8", capAcc[2], 64'd96);
        checkVal("clear satU", 64'(capSat[0]), 64'd0);

        $display("[TB] reset with four beats in flight");
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, b == 3, 1'b0, allLanes(3));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clearCaptures();
        repeat (N_STAGE + 3) tick();
        checkVal("post-reset tree pulses", 64'(tvCnt), 64'd0);
        checkVal("post-reset acc pulses", 64'(avCnt), 64'd0);
        checkVal("post-reset acc_out", actAo[0], 64'd0);
        checkVal("post-reset acc_outS", actAo[1], 64'd0);
        checkVal("post-reset tree_sum", actTs[0], 64'd0);
        measureLatency(1, 32);

        $display("[TB] randomized traffic against the model");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 16) == 0,
                          {$urandom, $urandom});
            rst_n = (($urandom % 100) != 0);
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        repeat (N_STAGE + 3) tick();

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
Parametrised, pipelined successor to the team's combinational weighted-input adder tree. It sums 2**N_STAGE weighted synapse contributions of W_IN bits each, signed or unsigned. A register sits after every adder stage, and a valid bit travels alongside the data. A saturating accumulator after the tree integrates multi-beat (time-multiplexed) neuron inputs and delivers one total per frame. It sits between the synapse weight-multiply lanes and the neuron membrane update.

Parameters:
N_STAGE, 5, number of adder stages; input lane count N_IN = 2**N_STAGE
W_IN, 2, width of each input lane
SIGNED, 0, 0 = unsigned lanes/arithmetic, 1 = two's-complement lanes/arithmetic
ACC_W, 16, accumulator width; must satisfy ACC_W >= W_IN+N_STAGE (elaboration error otherwise)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  wx holds a beat this cycle
in_last  input  1  beat is the final beat of a frame; qualified by in_valid
wx  input  W_IN*2**N_STAGE  lane j = wx[W_IN*j +: W_IN]
clear  input  1  synchronous accumulator flush
tree_valid  output  1  tree_sum holds a per-beat sum
tree_sum  output  W_IN+N_STAGE  per-beat sum, sign-extended per SIGNED
acc_valid  output  1  one-cycle pulse: acc_out holds a new frame total
acc_out  output  ACC_W  frame total, held until the next total
acc_sat  output  1  frame total was clipped; valid with acc_valid, held with acc_out

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low; one clock, no other clock or reset inputs.
- Reset, with rst_n low at a rising edge: all stage valid bits, tree_valid, acc_valid, acc_sat = 0; tree_sum, acc_out = 0; accumulator and pending-last flags = 0. Stage data registers need not be reset, but outputs must read 0 while their valid bit is 0 after reset.
- Tree: stage s (1..N_STAGE) adds adjacent pairs from stage s-1. Lane 2k pairs with lane 2k+1. Each stage is 1 bit wider than its input: W_IN+s. Operands are sign-extended if SIGNED, else zero-extended. Exact arithmetic, no overflow possible.
- A pipeline register follows each stage. A beat with in_valid=1 in cycle c appears as tree_valid=1 and tree_sum in cycle c+N_STAGE.
- in_last travels with the beat. Beats may arrive back-to-back every cycle, and gaps are allowed. There is no backpressure.
- in_valid=0 cycles produce tree_valid=0. Data and in_last are ignored when in_valid=0.
- Accumulator: in a cycle with tree_valid=1, the next value is sat(acc + tree_sum). tree_sum is extended to ACC_W per SIGNED.
  - Unsigned saturation clips to 2**ACC_W-1.
  - Signed saturation clips to [-2**(ACC_W-1), 2**(ACC_W-1)-1].
  - Any clip within a frame sets a sticky frame_sat flag.
- Last beat: if the beat reaching the accumulator carries last, then at that edge:
  - acc_out <= sat(acc + tree_sum);
  - acc_sat <= frame_sat OR this-beat clip;
  - acc <= 0, frame_sat <= 0;
  - acc_valid = 1 in the following cycle (c+N_STAGE+1), and 0 otherwise.
- A single-beat frame (in_last on the first beat) gives acc_out = tree_sum.
- clear=1 at an edge:
  - acc <= 0 and frame_sat <= 0;
  - any beat reaching the accumulator that same cycle is dropped, including its last flag, so no acc_valid results;
  - acc_out and acc_sat keep their previous values;
  - beats still in the tree are unaffected and arrive afterwards normally.
- rst_n=0 has priority over clear. clear has priority over accumulation.
- Reset mid-operation discards all in-flight beats. No tree_valid or acc_valid may appear from pre-reset beats.

Test Plan:
- Default params, all lanes = 3, in_valid=1, in_last=1 in cycle 10 -> tree_valid & tree_sum=96 in cycle 15; acc_valid, acc_out=96, acc_sat=0 in cycle 16.
- SIGNED=1, W_IN=2, all lanes = 2'b10 (-2), single beat -> tree_sum=-64 (7'b1000000); acc_out=-64 sign-extended to 16 bits.
- Default params, 3 back-to-back beats of all-3s, in_last on the third -> exactly one acc_valid, acc_out=288, tree_valid high for 3 consecutive cycles.
- ACC_W=8 unsigned, same 3-beat frame -> acc_out=255, acc_sat=1. Next frame with one beat of all-1s (sum 32) -> acc_out=32, acc_sat=0.
- Frame of beats 96 then 96 (last), clear asserted in the cycle the first beat reaches the accumulator -> acc_out=96.
- 4 beats in flight, rst_n low for 1 cycle -> no tree_valid or acc_valid afterwards, all outputs 0. A fresh beat after reset yields correct latency N_STAGE.
